// File: rtl/uart_frame_sequencer.sv
// Frames one cipher block as SYNC, sequence number, payload (MSB first), XOR checksum
// and hands it to a byte-wide UART transmitter one byte at a time.
module uart_frame_sequencer #(
    parameter int         BLOCK_BYTES = 8,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [8*BLOCK_BYTES-1:0] blk_data,
    input  logic                     blk_valid,
    output logic                     blk_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic [7:0]               seq_num,
    output logic                     frame_done
);

    // state   | meaning
    // IDLE    | waiting for a block, blk_ready high
    // SEND    | current byte on tx_data, start it once the UART is free
    // HOLD    | one cycle for the UART's busy flag to rise
    // WAIT    | byte in flight, wait for busy to drop
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    localparam int         W        = 8 * BLOCK_BYTES;
    localparam logic [5:0] LAST_IDX = 6'(BLOCK_BYTES + 2);

    logic [1:0]   state;
    logic [W-1:0] shreg;
    logic [7:0]   chk;
    logic [5:0]   idx;
    logic [7:0]   seq_r;
    logic         done_r;
    logic [7:0]   cur_byte;

    // Byte index: 0 = sync, 1 = sequence number, last = checksum, otherwise payload.
    always_comb begin
        cur_byte = shreg[W-1 -: 8];
        if (idx == 6'd0)
            cur_byte = SYNC_BYTE;
        else if (idx == 6'd1)
            cur_byte = seq_r;
        else if (idx == LAST_IDX)
            cur_byte = chk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            shreg  <= '0;
            chk    <= 8'h00;
            idx    <= 6'd0;
            seq_r  <= 8'h00;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (blk_valid) begin
                        shreg <= blk_data;
                        chk   <= 8'h00;
                        idx   <= 6'd0;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!tx_busy)
                        state <= ST_HOLD;
                end
                ST_HOLD: state <= ST_WAIT;
                ST_WAIT: begin
                    if (!tx_busy) begin
                        if (idx == LAST_IDX) begin
                            done_r <= 1'b1;
                            seq_r  <= seq_r + 8'd1;
                            state  <= ST_IDLE;
                        end else begin
                            idx <= idx + 6'd1;
                            // Checksum covers everything after the sync byte.
                            if (idx != 6'd0)
                                chk <= chk ^ cur_byte;
                            if (idx >= 6'd2)
                                shreg <= shreg << 8;
                            state <= ST_SEND;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign blk_ready  = (state == ST_IDLE);
    assign tx_start   = (state == ST_SEND) && !tx_busy;
    assign tx_data    = (state == ST_IDLE) ? 8'h00 : cur_byte;
    assign seq_num    = seq_r;
    assign frame_done = done_r;

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Scoreboard bench for uart_frame_sequencer: frame model feeds expected bytes,
// a negedge monitor with a UART model pops and compares every issued byte.
module tb_uart_frame_sequencer;
    localparam int BB = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [8*BB-1:0] blk_data;
    logic          blk_valid;
    logic          blk_ready;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic [7:0]    seq_num;
    logic          frame_done;

    logic uart_busy = 1'b0;
    logic uart_pend = 1'b0;
    logic ext_busy  = 1'b0;
    int   uart_cnt  = 0;
    int   uart_len  = 20;

    assign tx_busy = uart_busy | ext_busy;

    uart_frame_sequencer #(.BLOCK_BYTES(BB), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .blk_data(blk_data), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .seq_num(seq_num), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    logic [7:0] exp_bytes[$];
    logic [7:0] exp_seq[$];
    logic [7:0] model_seq = 8'h00;
    int   cyc = 0;
    int   frame_bytes = 0;
    int   done_cyc = -100;
    int   done_count = 0;
    logic prev_start = 1'b0;
    bit   b2b_arm = 0;
    bit   b2b_chk = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference frame: sync, seq, payload MSB first, XOR of everything but sync.
    task automatic push_frame(input logic [8*BB-1:0] d);
        logic [7:0] c;
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(model_seq);
        c = model_seq;
        for (int i = BB - 1; i >= 0; i--) begin
            exp_bytes.push_back(d[8*i +: 8]);
            c = c ^ d[8*i +: 8];
        end
        exp_bytes.push_back(c);
        model_seq = model_seq + 8'd1;
        exp_seq.push_back(model_seq);
    endtask

    always @(posedge clk) cyc++;

    // Monitor plus UART model: sample first, then advance the UART's busy flag.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_start) begin
                check("start_while_busy", tx_busy, 0);
                check("start_consecutive", prev_start, 0);
                if (exp_bytes.size() == 0) fail_now("unexpected_byte");
                else check("tx_byte", tx_data, exp_bytes.pop_front());
                frame_bytes++;
                if (b2b_chk) begin
                    check("b2b_gap", cyc - done_cyc, 1);
                    b2b_chk = 0;
                end
            end
            if (frame_done) begin
                check("ready_with_done", blk_ready, 1);
                check("frame_len", frame_bytes, BB + 3);
                if (exp_seq.size() == 0) fail_now("unexpected_frame_done");
                else check("seq_after_frame", seq_num, exp_seq.pop_front());
                frame_bytes = 0;
                done_cyc = cyc;
                done_count++;
                if (b2b_arm) begin
                    b2b_chk = 1;
                    b2b_arm = 0;
                end
            end
        end
        prev_start = tx_start;
        if (uart_pend) begin
            uart_pend = 1'b0;
            uart_busy = 1'b1;
            uart_cnt  = uart_len;
        end else if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) uart_busy = 1'b0;
        end
        if (tx_start && !rst) uart_pend = 1'b1;
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!blk_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!blk_ready) fail_now("timeout_blk_ready");
    endtask

    task automatic send_block(input logic [8*BB-1:0] d, input bit expect_start);
        wait_ready();
        blk_data  = d;
        blk_valid = 1'b1;
        push_frame(d);
        @(posedge clk);
        @(negedge clk);
        blk_valid = 1'b0;
        #1;
        if (expect_start) check("first_start_latency", tx_start, 1);
    endtask

    task automatic wait_quiet();
        int n = 0;
        while (n < 5000 && !(exp_bytes.size() == 0 && exp_seq.size() == 0 &&
                             blk_ready && !uart_busy && !uart_pend)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            fail_now("timeout_frame");
            exp_bytes.delete();
            exp_seq.delete();
        end
    endtask

    initial begin
        logic [8*BB-1:0] d1;
        logic [8*BB-1:0] d2;
        int n;
        int start_done;

        rst = 1'b1;
        blk_valid = 1'b0;
        blk_data = '0;
        #1;
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_frame_done", frame_done, 0);
        check("rst_seq_num", seq_num, 8'h00);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1 check("rst_blk_ready", blk_ready, 1);

        // Basic frames with a 20-cycle UART.
        send_block(64'h0123456789ABCDEF, 1);
        wait_quiet();
        check("seq_after_basic", seq_num, 8'h01);
        send_block(64'h0, 1);
        wait_quiet();
        check("seq_after_zero", seq_num, 8'h02);

        // Busy held externally at accept.
        @(posedge clk);
        #2 ext_busy = 1'b1;
        send_block({$urandom, $urandom}, 0);
        repeat (50) @(negedge clk);
        check("held_no_start", frame_bytes, 0);
        @(posedge clk);
        #2 ext_busy = 1'b0;
        @(negedge clk);
        #1 check("start_after_release", frame_bytes, 1);
        wait_quiet();

        // Back-to-back with blk_valid held.
        d1 = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        wait_ready();
        blk_data  = d1;
        blk_valid = 1'b1;
        push_frame(d1);
        @(posedge clk);
        @(negedge clk);
        b2b_arm  = 1;
        blk_data = d2;
        push_frame(d2);
        start_done = done_count;
        n = 0;
        while (n < 3000 && !(done_count > start_done && !blk_ready)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now("timeout_b2b");
        blk_valid = 1'b0;
        wait_quiet();
        check("b2b_seq", seq_num, 8'h05);

        // Reset mid-payload.
        send_block({$urandom, $urandom}, 1);
        n = 0;
        while (n < 3000 && frame_bytes < 5) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now("timeout_mid_frame");
        @(posedge clk);
        #2 rst = 1'b1;
        exp_bytes.delete();
        exp_seq.delete();
        model_seq = 8'h00;
        frame_bytes = 0;
        #1;
        check("midrst_tx_start", tx_start, 0);
        check("midrst_seq_num", seq_num, 8'h00);
        check("midrst_tx_data", tx_data, 8'h00);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("midrst_blk_ready", blk_ready, 1);
        wait_quiet();
        send_block({$urandom, $urandom}, 1);
        wait_quiet();

        // Sequence wrap with random data and short random UART busy times.
        for (int f = 0; f < 255; f++) begin
            uart_len = $urandom_range(1, 5);
            send_block({$urandom, $urandom}, 1);
            wait_quiet();
        end
        check("seq_wrapped", seq_num, 8'h00);
        uart_len = 20;
        send_block({$urandom, $urandom}, 1);
        wait_quiet();
        check("seq_after_wrap", seq_num, 8'h01);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
